// File: rtl/pipeline_if.sv
// Instruction-fetch stage: PC, req/ack fetch from instruction memory, one-entry skid buffer.
// Optional macro IF_MISALIGN_CHECK_EN traps misaligned redirect targets on exc_misalign.
//
// state | meaning
// BOOT  | first cycle after reset release, no request yet
// FETCH | request outstanding at imem_addr, results flow to decode
// HOLD  | decode stalled with a fetched word parked in the skid buffer
// TRAP  | misaligned redirect reported, fetch idle until next redirect
module pipeline_if #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic        exc_misalign
);

   typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HOLD, ST_TRAP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic        exc_misalign_q, exc_misalign_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;

   logic [31:0] target;
   logic        misalign;
   logic        fetch_ok;
   logic [31:0] pc_plus4;

`ifdef IF_MISALIGN_CHECK_EN
   assign target   = redirect_pc;
   assign misalign = (redirect_pc[1:0] != 2'b00);
`else
   assign target   = redirect_pc & ~32'd3;
   assign misalign = 1'b0;
`endif

   assign fetch_ok = imem_req_q & imem_ack;
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      imem_addr_d    = imem_addr_q;
      imem_req_d     = imem_req_q;
      inst_d         = inst_q;
      inst_pc_d      = inst_pc_q;
      inst_valid_d   = inst_valid_q;
      exc_misalign_d = exc_misalign_q;
      skid_valid_d   = skid_valid_q;
      skid_inst_d    = skid_inst_q;
      skid_pc_d      = skid_pc_q;

      if (redirect) begin
         // Redirect beats stall and discards any same-cycle ack.
         pc_d         = target;
         imem_addr_d  = target;
         skid_valid_d = 1'b0;
         inst_d       = NOP_INST;
         if (misalign) begin
            exc_misalign_d = 1'b1;
            inst_pc_d      = redirect_pc;
            inst_valid_d   = 1'b1;
            imem_req_d     = 1'b0;
            state_d        = ST_TRAP;
         end else begin
            exc_misalign_d = 1'b0;
            inst_valid_d   = 1'b0;
            imem_req_d     = 1'b1;
            state_d        = ST_FETCH;
         end
      end else begin
         case (state_q)
            ST_BOOT: begin
               imem_req_d  = 1'b1;
               imem_addr_d = pc_q;
               state_d     = ST_FETCH;
            end
            ST_FETCH: begin
               if (!stall) begin
                  if (fetch_ok) begin
                     inst_d       = imem_data;
                     inst_pc_d    = imem_addr_q;
                     inst_valid_d = 1'b1;
                     pc_d         = pc_plus4;
                     imem_addr_d  = pc_plus4;
                  end else begin
                     inst_d       = NOP_INST;
                     inst_valid_d = 1'b0;
                  end
               end else if (fetch_ok) begin
                  skid_valid_d = 1'b1;
                  skid_inst_d  = imem_data;
                  skid_pc_d    = imem_addr_q;
                  pc_d         = pc_plus4;
                  imem_req_d   = 1'b0;
                  state_d      = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  inst_d       = skid_inst_q;
                  inst_pc_d    = skid_pc_q;
                  inst_valid_d = skid_valid_q;
                  skid_valid_d = 1'b0;
                  imem_req_d   = 1'b1;
                  imem_addr_d  = pc_q;
                  state_d      = ST_FETCH;
               end
            end
            ST_TRAP: begin
               if (inst_valid_q && !stall) begin
                  exc_misalign_d = 1'b0;
                  inst_valid_d   = 1'b0;
               end
            end
            default: state_d = ST_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_BOOT;
         pc_q           <= RESET_PC;
         imem_addr_q    <= RESET_PC;
         imem_req_q     <= 1'b0;
         inst_q         <= NOP_INST;
         inst_pc_q      <= 32'd0;
         inst_valid_q   <= 1'b0;
         exc_misalign_q <= 1'b0;
         skid_valid_q   <= 1'b0;
         skid_inst_q    <= NOP_INST;
         skid_pc_q      <= 32'd0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         imem_addr_q    <= imem_addr_d;
         imem_req_q     <= imem_req_d;
         inst_q         <= inst_d;
         inst_pc_q      <= inst_pc_d;
         inst_valid_q   <= inst_valid_d;
         exc_misalign_q <= exc_misalign_d;
         skid_valid_q   <= skid_valid_d;
         skid_inst_q    <= skid_inst_d;
         skid_pc_q      <= skid_pc_d;
      end
   end

   assign imem_req     = imem_req_q;
   assign imem_addr    = imem_addr_q;
   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;
   assign inst_valid   = inst_valid_q;
   assign exc_misalign = exc_misalign_q;

endmodule

// File: doc/pipeline_if.md
Name: pipeline_if

Overview:
- Instruction-fetch stage; the producer end of the 32-bit instruction interface consumed by the decode stage.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents inst/inst_pc/inst_valid to decode, honours the decode stall, and accepts branch/jump redirects from later stages.
- One-entry skid buffer absorbs a fetch that returns while decode is stalled.

Parameters:
RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address
NOP_INST  32'h0000_0013  encoding driven on inst when no valid instruction (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, word aligned in normal operation
imem_ack  input  1  imem_data valid for the current imem_addr this cycle; only meaningful while imem_req=1
imem_data  input  32  fetched instruction word
stall  input  1  decode cannot accept; inst/inst_pc/inst_valid must hold
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch target
inst  output  32  instruction to decode
inst_pc  output  32  address of inst
inst_valid  output  1  inst is a real instruction
exc_misalign  output  1  misaligned redirect target (see Optional Feature; tied 0 when disabled)

Behaviour:
- Reset, async, any state: pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, inst=NOP_INST, inst_pc=0, inst_valid=0, exc_misalign=0, skid buffer empty, state=BOOT.
- Memory protocol: no outstanding transactions. A cycle with imem_req=1 and imem_ack=1 completes the fetch of imem_addr. imem_addr may change while req is high; an un-acked request is simply abandoned.
- Consumption: decode takes the output when inst_valid=1 and stall=0 at a clock edge.
- States:
  - BOOT: one cycle after reset release. Next: imem_req<=1, imem_addr<=pc, go to FETCH.
  - FETCH, stall=0, ack=1: inst<=imem_data, inst_pc<=imem_addr, inst_valid<=1, pc/imem_addr<=pc+4, req stays 1. Sustains one instruction per cycle with zero-wait memory.
  - FETCH, stall=0, ack=0: inst_valid<=0, inst<=NOP_INST (bubble); address held.
  - FETCH, stall=1, ack=0: outputs hold; address held.
  - FETCH, stall=1, ack=1: word and pc go into the skid buffer; pc<=pc+4; imem_req<=0; go to HOLD.
  - HOLD, stall=1: everything holds; req=0.
  - HOLD, stall=0: skid buffer moves to the outputs (inst_valid<=1), buffer empties, imem_req<=1, imem_addr<=pc, go to FETCH.
- Redirect has the highest priority in every state and overrides stall:
  - pc<=redirect_pc, imem_addr<=redirect_pc, imem_req<=1.
  - Skid buffer is cleared; inst_valid<=0; inst<=NOP_INST.
  - An ack in the same cycle is discarded.
  - Go to FETCH; the first new instruction can appear on the next edge after a same-cycle ack.
- Redirect during BOOT: taken; BOOT fetch of RESET_PC is skipped.
- PC arithmetic: 32-bit modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000, no flag.
- imem_addr is never incremented speculatively beyond one word past the last accepted fetch.
- Reset asserted mid-fetch or in HOLD: immediate return to reset values; the pending memory request is dropped (req=0 asynchronously).

Optional Feature:
- Macro IF_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets exc_misalign<=1, inst_pc<=redirect_pc, inst_valid<=1, inst<=NOP_INST, imem_req<=0, state=HOLD-like idle.
  - exc_misalign holds under stall and clears when consumed.
  - Fetch resumes only on the next redirect.
- Undefined: exc_misalign tied 0; redirect_pc[1:0] forced to 0 in pc/imem_addr.

Test Plan:
- Reset release, memory ack every cycle, stall=0 -> imem_addr 0x0,0x4,0x8...; inst_pc 0x0,0x4,... one per cycle from the 2nd edge after BOOT; inst matches memory.
- Ack withheld 3 cycles on 0x8 -> inst_valid=0 with inst=0x00000013 for 3 cycles; imem_addr holds 0x8; then 0x8 delivered.
- stall=1 for 4 cycles while ack on 0xC -> outputs hold 0x8 instruction, imem_req drops, 0xC buffered; stall=0 -> 0xC appears next edge, fetch resumes at 0x10.
- redirect=1, redirect_pc=0x200 while in HOLD with stall=1 -> buffer discarded, inst_valid=0, imem_addr=0x200, next instruction inst_pc=0x200 (0xC never issued).
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
- IF_MISALIGN_CHECK_EN on, redirect_pc=0x102 -> exc_misalign=1, inst_pc=0x102, imem_req=0 until redirect to 0x100. Off -> fetch at 0x100.
